// File: rtl/acc_burst_32_if.sv
// acc_burst_32_if
// Bundles the start/length request, the input word stream, the adder
// operand/sum loop and the result stream of acc_burst_32.
//   start, len            burst request (len is CNT_W bits, 0 is legal)
//   busy                  controller is in a burst or holding a result
//   in_valid/in_ready     32-bit input word stream, in_data
//   add_a, add_b, add_sum operands to and 33-bit sum from the external adder
//   res_valid/res_ready   result stream, res_data is 32+CNT_W bits
// Modport slave is the controller's view; master is the environment's view.
interface acc_burst_32_if #(
    parameter int CNT_W = 8
);
    logic                  start;
    logic [CNT_W-1:0]      len;
    logic                  busy;
    logic                  in_valid;
    logic [31:0]           in_data;
    logic                  in_ready;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic [32:0]           add_sum;
    logic                  res_valid;
    logic                  res_ready;
    logic [32+CNT_W-1:0]   res_data;

    modport slave (
        input  start, len, in_valid, in_data, add_sum, res_ready,
        output busy, in_ready, add_a, add_b, res_valid, res_data
    );

    modport master (
        output start, len, in_valid, in_data, add_sum, res_ready,
        input  busy, in_ready, add_a, add_b, res_valid, res_data
    );
endinterface

// File: rtl/acc_burst_32.sv
// acc_burst_32
// Accumulates a burst of N unsigned 32-bit words. The low word is summed by
// an external 33-bit-result adder (add_a = running low word, add_b = incoming
// word); each carry-out is folded into the upper accumulator bits, so the
// (32+CNT_W)-bit total can never overflow for N <= 2^CNT_W-1.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   acc_burst_32_if.slave: start/len, busy, in_* stream,
//         add_a/add_b/add_sum adder loop, res_* stream
module acc_burst_32 #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    acc_burst_32_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;      // words still to accept
    logic [31:0]        acc_lo;
    logic [CNT_W-1:0]   acc_hi;
    logic               busy_q;
    logic               in_ready_q;
    logic               res_valid_q;
    logic               beat;

    assign beat = bus.in_valid & in_ready_q;

    // NOTE: all state lives in this one block and uses non-blocking
    // assignments, so every register sees the pre-edge value of the others
    // (e.g. acc_hi increments from its old value while acc_lo takes add_sum).
    // The status outputs are flops updated alongside state, so they change
    // exactly when the state does and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_lo      <= '0;
            acc_hi      <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_lo <= '0;
                        acc_hi <= '0;
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            cnt        <= bus.len;
                            in_ready_q <= 1'b1;
                            state      <= ACC;
                        end else begin
                            // Empty burst: present the zero total at once.
                            res_valid_q <= 1'b1;
                            state       <= OUT;
                        end
                    end
                end

                ACC: begin
                    if (beat) begin
                        acc_lo <= bus.add_sum[31:0];
                        acc_hi <= acc_hi + CNT_W'(bus.add_sum[32]);
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            in_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                            state       <= OUT;
                        end
                    end
                end

                OUT: begin
                    // Accumulator is left untouched so the last total stays
                    // visible on res_data while idle.
                    if (bus.res_ready) begin
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = {acc_hi, acc_lo};
    assign bus.add_a     = acc_lo;
    assign bus.add_b     = bus.in_data;

endmodule

// File: tb/tb_acc_burst_32.sv
// tb_acc_burst_32
// Drives acc_burst_32 through its interface, closes the adder loop with an
// arithmetic adder, and compares against hand-computed table entries, a few
// directed multi-cycle sequences, and a plain-arithmetic sum of random bursts.
module tb_acc_burst_32;

    localparam int CW = 8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    acc_burst_32_if #(.CNT_W(CW)) bus ();

    acc_burst_32 #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External adder: 33-bit result, combinational.
    assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required to end by 2000000");
        $fatal(1, "timeout");
    end

    typedef struct {
        int unsigned n;
        logic [31:0] base;
        logic [31:0] stride;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res_data"},  64'(bus.res_data),  64'd0);
        check({tag, "_add_a"},     64'(bus.add_a),     64'd0);
    endtask

    // One burst with continuous in_valid and res_ready=1; words are
    // base, base+stride, ... Called in an IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        string       tag;
        logic [31:0] w;
        logic [63:0] run;
        tag = $sformatf("vec%0d", idx);
        bus.start     = 1'b1;
        bus.len       = CW'(v.n);
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b0;
        step();
        bus.start = 1'b0;
        bus.len   = '0;
        check({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        run = '0;
        w   = v.base;
        for (int i = 0; i < int'(v.n); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w;
            #1;
            check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
            check({tag, "_add_a"}, 64'(bus.add_a), 64'(run[31:0]));
            if (i == 0) check({tag, "_add_b"}, 64'(bus.add_b), 64'(w));
            run = run + 64'(w);
            w   = w + v.stride;
            step();
        end
        bus.in_valid = 1'b0;
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
        check({tag, "_in_ready_out"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_res_data"}, 64'(bus.res_data), v.exp);
        step();
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_res_valid_done"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res_data_kept"}, 64'(bus.res_data), v.exp);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{n: 3,   base: 32'd1,          stride: 32'd1,  exp: 64'd6};
        vecs[1] = '{n: 4,   base: 32'hFFFF_FFFF,  stride: 32'd0,  exp: 64'h3_FFFF_FFFC};
        vecs[2] = '{n: 0,   base: 32'd0,          stride: 32'd0,  exp: 64'd0};
        vecs[3] = '{n: 255, base: 32'hFFFF_FFFF,  stride: 32'd0,  exp: 64'hFE_FFFF_FF01};
        vecs[4] = '{n: 1,   base: 32'd7,          stride: 32'd0,  exp: 64'd7};
        vecs[5] = '{n: 2,   base: 32'h8000_0000,  stride: 32'd0,  exp: 64'h1_0000_0000};
        vecs[6] = '{n: 5,   base: 32'd10,         stride: 32'd10, exp: 64'd150};

        // Reset then idle.
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_reset_outputs("reset_idle");

        // Table of back-to-back bursts.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Input stall: len=2, in_valid 1,0,0,1.
        begin
            logic [3:0] vpat;
            logic [31:0] seq_words [2];
            int k;
            vpat = 4'b1001;
            seq_words[0] = 32'd5;
            seq_words[1] = 32'd9;
            k = 0;
            bus.start = 1'b1;
            bus.len   = CW'(2);
            step();
            bus.start = 1'b0;
            for (int c = 0; c < 4; c++) begin
                bus.in_valid = vpat[c];
                bus.in_data  = vpat[c] ? seq_words[k] : 32'hDEAD_0000 + 32'(c);
                #1;
                if (c == 1 || c == 2) check("stall_add_a_hold", 64'(bus.add_a), 64'd5);
                if (vpat[c]) k++;
                step();
            end
            bus.in_valid = 1'b0;
            check("stall_res_valid", 64'(bus.res_valid), 64'd1);
            check("stall_res_data", 64'(bus.res_data), 64'd14);
            bus.res_ready = 1'b1;
            step();
            bus.res_ready = 1'b0;
            check("stall_idle", 64'(bus.busy), 64'd0);
        end

        // Output backpressure, start and in_valid ignored while busy.
        bus.start = 1'b1;
        bus.len   = CW'(1);
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234;
        step();
        bus.start     = 1'b1;
        bus.len       = CW'(3);
        bus.in_data   = 32'h5555;
        bus.res_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("bp_res_valid", 64'(bus.res_valid), 64'd1);
            check("bp_res_data", 64'(bus.res_data), 64'h1234);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            step();
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("bp_idle_busy", 64'(bus.busy), 64'd0);
        step();
        check("bp_start_ignored", 64'(bus.busy), 64'd0);
        check("bp_no_extra_word", 64'(bus.res_data), 64'h1234);
        bus.in_valid = 1'b0;

        // Reset mid-burst, pending word not consumed.
        bus.start = 1'b1;
        bus.len   = CW'(5);
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(c + 3);
            step();
        end
        bus.in_data = 32'h99;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_reset_outputs("mid_reset");
        run_vec('{n: 1, base: 32'd7, stride: 32'd0, exp: 64'd7}, 100);

        // Random bursts against a plain-sum model.
        for (int b = 0; b < 40; b++) begin
            int unsigned n;
            int unsigned beats;
            int budget;
            int stall;
            logic [63:0] total;
            logic [31:0] d;
            n = $urandom_range(0, 12);
            beats = 0;
            budget = 0;
            total = '0;
            bus.start = 1'b1;
            bus.len   = CW'(n);
            step();
            while (beats < n && budget < 200) begin
                // start may wiggle during the burst; it must be ignored.
                bus.start    = 1'($urandom_range(0, 1));
                bus.len      = CW'($urandom);
                bus.in_valid = 1'($urandom_range(0, 1));
                d = $urandom;
                bus.in_data  = d;
                #1;
                check("rand_in_ready", 64'(bus.in_ready), 64'd1);
                check("rand_add_a", 64'(bus.add_a), 64'(total[31:0]));
                if (bus.in_valid) begin
                    total = total + 64'(d);
                    beats++;
                end
                step();
                budget++;
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            check("rand_within_budget", 64'(beats), 64'(n));
            stall = $urandom_range(0, 3);
            bus.res_ready = 1'b0;
            for (int c = 0; c < stall; c++) begin
                check("rand_hold_valid", 64'(bus.res_valid), 64'd1);
                step();
            end
            bus.res_ready = 1'b1;
            check("rand_res_valid", 64'(bus.res_valid), 64'd1);
            check("rand_res_data", 64'(bus.res_data), total);
            step();
            bus.res_ready = 1'b0;
            check("rand_idle", 64'(bus.busy), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
